// File: rtl/vec_dot_feeder_if.sv
// Element-pair input stream and result output stream between the feeder and its
// upstream/downstream neighbours. The feeder uses the slave modport.
interface vec_dot_feeder_if #(
  parameter int DW = 16
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;
  logic          res_err;

  modport master (
    output in_valid, in_a, in_b, res_ready,
    input  in_ready, res_valid, res_data, res_err
  );

  modport slave (
    input  in_valid, in_a, in_b, res_ready,
    output in_ready, res_valid, res_data, res_err
  );
endinterface

// File: rtl/vec_dot_feeder.sv
// Packs serial (a,b) element pairs into vectors for the vec_dot engine, runs it,
// and hands back its result (or a timeout error) over a valid/ready port.
//
// state | meaning
// FILL  | accepting element pairs, packing MSB slice first
// RUN   | engine enabled, waiting for dot_finish or timeout
// HOLD  | result presented, waiting for downstream handshake
// CLEAR | one-cycle engine reset before refilling
module vec_dot_feeder #(
  parameter int DW      = 16,
  parameter int N_ELEM  = 16,
  parameter int TIMEOUT = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  vec_dot_feeder_if.slave      io,
  output logic [DW*N_ELEM-1:0] vec_a_out,
  output logic [DW*N_ELEM-1:0] vec_b_out,
  output logic                 dot_en,
  output logic                 dot_rst,
  input  logic [DW-1:0]        dot_out_in,
  input  logic                 dot_finish,
  output logic                 busy
);

  localparam int CW = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(N_ELEM - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {FILL, RUN, HOLD, CLEAR} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [TW-1:0] tmo;

  // The engine is held in reset whenever we are, not just in CLEAR.
  assign dot_rst = rst | (state == CLEAR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FILL;
      count        <= '0;
      tmo          <= '0;
      vec_a_out    <= '0;
      vec_b_out    <= '0;
      dot_en       <= 1'b0;
      busy         <= 1'b0;
      io.in_ready  <= 1'b0;
      io.res_valid <= 1'b0;
      io.res_data  <= '0;
      io.res_err   <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          io.in_ready <= 1'b1;
          if (io.in_valid && io.in_ready) begin
            for (int k = 0; k < N_ELEM; k++) begin
              if (count == CW'(k)) begin
                vec_a_out[DW*(N_ELEM-1-k) +: DW] <= io.in_a;
                vec_b_out[DW*(N_ELEM-1-k) +: DW] <= io.in_b;
              end
            end
            busy <= 1'b1;
            if (count == LAST_IDX) begin
              count       <= '0;
              state       <= RUN;
              io.in_ready <= 1'b0;
              dot_en      <= 1'b1;
            end else begin
              count <= count + 1'b1;
            end
          end
        end

        RUN: begin
          tmo <= tmo + 1'b1;
          // A finish in the timeout cycle still reports the engine's result.
          if (dot_finish) begin
            io.res_data  <= dot_out_in;
            io.res_err   <= 1'b0;
            io.res_valid <= 1'b1;
            dot_en       <= 1'b0;
            state        <= HOLD;
          end else if (tmo == TMO_LAST) begin
            io.res_data  <= '0;
            io.res_err   <= 1'b1;
            io.res_valid <= 1'b1;
            dot_en       <= 1'b0;
            state        <= HOLD;
          end
        end

        HOLD: begin
          if (io.res_valid && io.res_ready) begin
            io.res_valid <= 1'b0;
            state        <= CLEAR;
          end
        end

        CLEAR: begin
          tmo         <= '0;
          state       <= FILL;
          io.in_ready <= 1'b1;
          busy        <= 1'b0;
        end

        default: begin
          state <= FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vec_dot_feeder.sv
// Randomized self-checking bench for vec_dot_feeder with an in-bench engine stand-in
// and a packing model built directly from the element order rule.
module tb_vec_dot_feeder;
  localparam int DW  = 16;
  localparam int N   = 16;
  localparam int TMO = 64;
  localparam int VW  = DW * N;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] dot_out_in = '0;
  logic          dot_finish = 1'b0;
  logic [VW-1:0] vec_a_out, vec_b_out;
  logic          dot_en, dot_rst, busy;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] pa[N];
  logic [DW-1:0] pb[N];

  vec_dot_feeder_if #(.DW(DW)) io ();

  vec_dot_feeder #(.DW(DW), .N_ELEM(N), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .io         (io),
    .vec_a_out  (vec_a_out),
    .vec_b_out  (vec_b_out),
    .dot_en     (dot_en),
    .dot_rst    (dot_rst),
    .dot_out_in (dot_out_in),
    .dot_finish (dot_finish),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected vector: element k occupies slice k counted from the MSB end.
  function automatic logic [VW-1:0] exp_vec(input bit use_b);
    logic [VW-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++)
      v[VW-1-DW*k -: DW] = use_b ? pb[k] : pa[k];
    return v;
  endfunction

  task automatic rand_packet();
    for (int k = 0; k < N; k++) begin
      pa[k] = DW'($urandom);
      pb[k] = DW'($urandom);
    end
  endtask

  // Presents one pair only when in_ready is seen high, so it is accepted at the next edge.
  task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b, output bit ok);
    int t;
    ok = 1'b0;
    t  = 0;
    while (!ok && t < 100) begin
      if (io.in_ready === 1'b1) begin
        io.in_valid = 1'b1;
        io.in_a     = a;
        io.in_b     = b;
        tick();
        io.in_valid = 1'b0;
        ok = 1'b1;
      end else begin
        tick();
      end
      t++;
    end
  endtask

  task automatic fill(input int gap, output int stalls);
    bit ok;
    stalls = 0;
    for (int k = 0; k < N; k++) begin
      push(pa[k], pb[k], ok);
      if (!ok) stalls++;
      if (k < N - 1) begin
        repeat (gap) begin
          io.in_a = DW'($urandom);
          io.in_b = DW'($urandom);
          tick();
        end
      end
    end
  endtask

  // Called on RUN cycle 0; asserts dot_finish during RUN cycle d.
  task automatic finish_after(input int d, input logic [DW-1:0] val);
    repeat (d) tick();
    dot_finish = 1'b1;
    dot_out_in = val;
    tick();
    dot_finish = 1'b0;
    dot_out_in = DW'($urandom);
  endtask

  task automatic drain(input int w);
    repeat (w) tick();
    io.res_ready = 1'b1;
    tick();
    io.res_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (dot_rst !== 1'b1) begin errors++; $display("FAIL reset_dot_rst: got %b want 1", dot_rst); end
    checks++; if (io.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", io.in_ready); end
    checks++; if (vec_a_out !== '0 || vec_b_out !== '0) begin errors++; $display("FAIL reset_vec: got %h / %h want 0", vec_a_out, vec_b_out); end
    checks++; if ({dot_en, io.res_valid, io.res_err, busy} !== 4'b0) begin errors++; $display("FAIL reset_flags: got en,rv,re,busy=%b want 0000", {dot_en, io.res_valid, io.res_err, busy}); end
    checks++; if (io.res_data !== '0) begin errors++; $display("FAIL reset_res_data: got %h want 0", io.res_data); end
    rst = 1'b0;
    #1;
    checks++; if (dot_rst !== 1'b0) begin errors++; $display("FAIL reset_release_dot_rst: got %b want 0", dot_rst); end
    tick();
    checks++; if (io.in_ready !== 1'b1) begin errors++; $display("FAIL reset_after_in_ready: got %b want 1", io.in_ready); end
  endtask

  task automatic test_packing();
    int stalls;
    for (int k = 0; k < N; k++) begin
      pa[k] = DW'(k);
      pb[k] = 16'h0800;
    end
    fill(0, stalls);
    checks++; if (stalls !== 0) begin errors++; $display("FAIL pack_stalls: got %0d want 0", stalls); end
    checks++; if (dot_en !== 1'b1) begin errors++; $display("FAIL pack_dot_en: got %b want 1", dot_en); end
    checks++; if (io.in_ready !== 1'b0) begin errors++; $display("FAIL pack_in_ready: got %b want 0", io.in_ready); end
    checks++; if (vec_a_out[255:240] !== 16'h0000 || vec_a_out[15:0] !== 16'h000F) begin errors++; $display("FAIL pack_a_ends: got %h,%h want 0000,000f", vec_a_out[255:240], vec_a_out[15:0]); end
    checks++; if (vec_a_out !== exp_vec(1'b0)) begin errors++; $display("FAIL pack_vec_a: got %h want %h", vec_a_out, exp_vec(1'b0)); end
    checks++; if (vec_b_out !== {N{16'h0800}}) begin errors++; $display("FAIL pack_vec_b: got %h want all 0800", vec_b_out); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pack_busy: got %b want 1", busy); end
  endtask

  task automatic test_completion();
    for (int c = 1; c < 5; c++) begin
      tick();
      checks++; if (dot_en !== 1'b1 || io.res_valid !== 1'b0) begin errors++; $display("FAIL run_wait: cycle %0d en=%b rv=%b want 1,0", c, dot_en, io.res_valid); end
    end
    finish_after(1, 16'h1800);
    checks++; if (io.res_valid !== 1'b1) begin errors++; $display("FAIL done_res_valid: got %b want 1", io.res_valid); end
    checks++; if (io.res_data !== 16'h1800) begin errors++; $display("FAIL done_res_data: got %h want 1800", io.res_data); end
    checks++; if (io.res_err !== 1'b0 || dot_en !== 1'b0) begin errors++; $display("FAIL done_err_en: got err=%b en=%b want 0,0", io.res_err, dot_en); end
  endtask

  task automatic test_backpressure();
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (io.res_valid !== 1'b1 || io.res_data !== 16'h1800 || io.in_ready !== 1'b0 || dot_rst !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable: cycle %0d rv=%b data=%h ir=%b drst=%b want 1,1800,0,0", c, io.res_valid, io.res_data, io.in_ready, dot_rst);
      end
    end
    io.res_ready = 1'b1;
    tick();
    io.res_ready = 1'b0;
    checks++; if (dot_rst !== 1'b1 || io.res_valid !== 1'b0 || io.in_ready !== 1'b0) begin errors++; $display("FAIL clear_cycle: drst=%b rv=%b ir=%b want 1,0,0", dot_rst, io.res_valid, io.in_ready); end
    tick();
    checks++; if (dot_rst !== 1'b0 || io.in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL after_clear: drst=%b ir=%b busy=%b want 0,1,0", dot_rst, io.in_ready, busy); end
    io.res_ready = 1'b1;
    repeat (3) tick();
    io.res_ready = 1'b0;
    checks++; if (io.res_valid !== 1'b0 || io.in_ready !== 1'b1 || dot_rst !== 1'b0) begin errors++; $display("FAIL stray_res_ready: rv=%b ir=%b drst=%b want 0,1,0", io.res_valid, io.in_ready, dot_rst); end
  endtask

  task automatic test_timeout();
    int stalls;
    int cyc;
    logic [DW-1:0] val;
    rand_packet();
    fill(0, stalls);
    cyc = 0;
    while (io.res_valid !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    checks++; if (cyc !== TMO) begin errors++; $display("FAIL timeout_cycles: got %0d want %0d", cyc, TMO); end
    checks++; if (io.res_err !== 1'b1 || io.res_data !== '0 || dot_en !== 1'b0) begin errors++; $display("FAIL timeout_result: err=%b data=%h en=%b want 1,0000,0", io.res_err, io.res_data, dot_en); end
    drain(2);
    // dot_finish in the very cycle the timeout fires must win
    rand_packet();
    val = DW'($urandom);
    fill(0, stalls);
    finish_after(TMO - 1, val);
    checks++; if (io.res_valid !== 1'b1 || io.res_err !== 1'b0 || io.res_data !== val) begin errors++; $display("FAIL finish_wins: rv=%b err=%b data=%h want 1,0,%h", io.res_valid, io.res_err, io.res_data, val); end
    drain(1);
    rand_packet();
    val = DW'($urandom);
    fill(0, stalls);
    finish_after(int'($urandom_range(0, 40)), val);
    checks++; if (io.res_err !== 1'b0 || io.res_data !== val || vec_a_out !== exp_vec(1'b0)) begin errors++; $display("FAIL after_timeout_normal: err=%b data=%h want 0,%h", io.res_err, io.res_data, val); end
    drain(0);
  endtask

  task automatic test_reset_mid_fill();
    bit ok;
    int stalls;
    logic [DW-1:0] val;
    rand_packet();
    for (int k = 0; k < 7; k++) push(pa[k], pb[k], ok);
    rst = 1'b1;
    #1;
    checks++; if (dot_rst !== 1'b1) begin errors++; $display("FAIL midrst_dot_rst: got %b want 1", dot_rst); end
    tick();
    rst = 1'b0;
    checks++; if (io.in_ready !== 1'b0 || busy !== 1'b0 || vec_a_out !== '0) begin errors++; $display("FAIL midrst_state: ir=%b busy=%b vec_a=%h want 0,0,0", io.in_ready, busy, vec_a_out); end
    tick();
    rand_packet();
    pa[0] = 16'h1234;
    push(pa[0], pb[0], ok);
    checks++; if (vec_a_out[255:240] !== 16'h1234 || dot_en !== 1'b0) begin errors++; $display("FAIL midrst_first: slice=%h en=%b want 1234,0", vec_a_out[255:240], dot_en); end
    for (int k = 1; k < N - 1; k++) push(pa[k], pb[k], ok);
    checks++; if (dot_en !== 1'b0 || io.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_15: en=%b ir=%b want 0,1", dot_en, io.in_ready); end
    push(pa[N-1], pb[N-1], ok);
    checks++; if (dot_en !== 1'b1 || vec_a_out !== exp_vec(1'b0) || vec_b_out !== exp_vec(1'b1)) begin errors++; $display("FAIL midrst_16: en=%b vec_a=%h want 1,%h", dot_en, vec_a_out, exp_vec(1'b0)); end
    val = DW'($urandom);
    finish_after(3, val);
    checks++; if (io.res_data !== val || io.res_err !== 1'b0) begin errors++; $display("FAIL midrst_result: data=%h err=%b want %h,0", io.res_data, io.res_err, val); end
    drain(0);
    stalls = 0;
  endtask

  task automatic test_sparse();
    int stalls;
    for (int k = 0; k < N; k++) begin
      pa[k] = DW'(k);
      pb[k] = 16'h0800;
    end
    fill(1, stalls);
    checks++; if (stalls !== 0 || dot_en !== 1'b1) begin errors++; $display("FAIL sparse_done: stalls=%0d en=%b want 0,1", stalls, dot_en); end
    checks++; if (vec_a_out !== exp_vec(1'b0) || vec_b_out !== exp_vec(1'b1)) begin errors++; $display("FAIL sparse_vec: vec_a=%h want %h", vec_a_out, exp_vec(1'b0)); end
    io.in_valid = 1'b1;
    io.in_a     = 16'hDEAD;
    io.in_b     = 16'hBEEF;
    finish_after(7, 16'h1800);
    repeat (3) tick();
    checks++; if (vec_a_out !== exp_vec(1'b0) || vec_b_out !== exp_vec(1'b1) || io.in_ready !== 1'b0) begin errors++; $display("FAIL sparse_no_extra: ir=%b vec_a=%h want 0,%h", io.in_ready, vec_a_out, exp_vec(1'b0)); end
    checks++; if (io.res_data !== 16'h1800 || io.res_valid !== 1'b1) begin errors++; $display("FAIL sparse_result: data=%h rv=%b want 1800,1", io.res_data, io.res_valid); end
    io.in_valid = 1'b0;
    drain(0);
    checks++; if (io.in_ready !== 1'b1 || busy !== 1'b0 || vec_a_out !== exp_vec(1'b0)) begin errors++; $display("FAIL sparse_refill: ir=%b busy=%b want 1,0", io.in_ready, busy); end
  endtask

  task automatic test_back_to_back();
    int stalls;
    logic [DW-1:0] val;
    for (int p = 0; p < 4; p++) begin
      rand_packet();
      val = DW'($urandom);
      fill(int'($urandom_range(0, 2)), stalls);
      checks++; if (vec_a_out !== exp_vec(1'b0) || vec_b_out !== exp_vec(1'b1) || stalls !== 0) begin errors++; $display("FAIL b2b_vec: pkt %0d vec_a=%h want %h", p, vec_a_out, exp_vec(1'b0)); end
      finish_after(int'($urandom_range(0, TMO - 1)), val);
      checks++; if (io.res_valid !== 1'b1 || io.res_data !== val || io.res_err !== 1'b0) begin errors++; $display("FAIL b2b_result: pkt %0d rv=%b data=%h err=%b want 1,%h,0", p, io.res_valid, io.res_data, io.res_err, val); end
      drain(int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    io.in_valid  = 1'b0;
    io.in_a      = '0;
    io.in_b      = '0;
    io.res_ready = 1'b0;
    test_reset();
    test_packing();
    test_completion();
    test_backpressure();
    test_timeout();
    test_reset_mid_fill();
    test_sparse();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
